axi_mem_responder: RTL and testbench
====================================

# axi_mem_responder

Synthesizable AXI4 slave that answers master-initiated burst traffic from an internal word-addressed memory. It is the RTL counterpart of the testbench's master VIP: it sits behind the interconnect inside `chip` and replaces the memory-model slave. Read and write channels run independent FSMs. Only full-width beats are supported; AxSIZE is not carried.

## Interface
- ADDR_WIDTH, 12, byte-address width.
- DATA_WIDTH, 32, data bus width; must be 32 or 64.
- ID_WIDTH, 4, transaction ID width.
- MEM_DEPTH, 1024, number of DATA_WIDTH words; must be a power of 2.
- aclk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- awid / awaddr / awlen / awburst  in  ID_WIDTH / ADDR_WIDTH / 8 / 2  write address: ID, start byte address, beats−1, burst type.
- awvalid / awready  in / out  1 / 1  write-address handshake.
- wdata / wstrb / wlast  in  DATA_WIDTH / DATA_WIDTH/8 / 1  write data, byte enables, last-beat flag.
- wvalid / wready  in / out  1 / 1  write-data handshake.
- bid / bresp  out  ID_WIDTH / 2  write response ID and code.
- bvalid / bready  out / in  1 / 1  write-response handshake.
- arid / araddr / arlen / arburst  in  ID_WIDTH / ADDR_WIDTH / 8 / 2  read address: ID, start byte address, beats−1, burst type.
- arvalid / arready  in / out  1 / 1  read-address handshake.
- rid / rdata / rresp / rlast  out  ID_WIDTH / DATA_WIDTH / 2 / 1  read ID, data, response code, last-beat flag.
- rvalid / rready  out / in  1 / 1  read-data handshake.

## Operation
- Word index = addr[log2(DATA_WIDTH/8) +: log2(MEM_DEPTH)]. Upper address bits are ignored (aliasing). Low byte-offset bits are ignored.
- Burst types:
  - FIXED (00): the address repeats on every beat.
  - INCR (01): +DATA_WIDTH/8 per beat.
  - WRAP (10): wraps at the boundary of (len+1)·DATA_WIDTH/8 bytes; len must be 1, 3, 7 or 15.
  - Reserved (11), or WRAP with an illegal len: runs as INCR and responds SLVERR (2'b10). Otherwise the response is OKAY (2'b00).
- Write FSM W_IDLE→W_DATA→W_RESP→W_IDLE:
  - awready=1 only in W_IDLE. The AW handshake latches id, addr, len and burst.
  - wready=1 only in W_DATA. Each accepted beat writes its strobed bytes.
  - The data phase ends on the first beat where wlast=1 or the beat count equals awlen. If those two do not coincide, bresp=SLVERR and no further beats are absorbed.
  - W_RESP drives bvalid=1, bid=latched id. It holds until bready.
- Read FSM R_IDLE→R_DATA→R_IDLE:
  - arready=1 only in R_IDLE.
  - rdata is a register loaded from memory on the AR handshake, and again on every non-last R handshake.
  - rlast=1 on beat arlen. rid and rresp hold for the whole burst.
- The read and write FSMs may run concurrently. When both access the same word in the same cycle, the read returns the old data.

## Timing
- Reset values while reset=1: awready, wready, bvalid, arready, rvalid and rlast are 0. bid, bresp, rid, rresp and rdata are 0.
- Both FSMs go to IDLE on reset, so awready=arready=1 on the first cycle after reset falls. Memory contents are not reset.
- AW handshake at cycle N → wready=1 at N+1.
- Last W beat at M → bvalid=1 at M+1.
- B handshake at K → awready=1 at K+1.
- AR handshake at N → rvalid=1 with beat 0 at N+1. Beats then stream one per cycle while rready=1.
- While rvalid=1 and rready=0, rdata, rlast, rid and rresp are held stable.
- Last R handshake at K → rvalid=0 and arready=1 at K+1.
- Reset asserted mid-burst aborts the burst immediately; no B or R response is issued for it.

## Structure
- Package axi_mem_pkg holds:
  - burst-type enum and response constants OKAY/SLVERR;
  - the W_* and R_* state enums;
  - function wrap_legal(len).
- Sub-module axi_mem_burst_addr: next-address generator (inputs: addr, burst, len, beat step). The top instantiates it twice, once per direction.

## Test plan
- INCR write: awaddr 0x100, len 3, wdata 0x11/0x22/0x33/0x44, wstrb 0xF. Then INCR read of the same burst → rdata 0x11, 0x22, 0x33, 0x44; rlast only on the 4th beat; bresp=rresp=2'b00.
- WRAP read: araddr 0x108, len 3, after filling 0x100–0x10C with 0xA0–0xA3 → beats 0xA2, 0xA3, 0xA0, 0xA1.
- Strobes: write 0xFFFFFFFF to 0x20, then 0xAABBCCDD to 0x20 with wstrb 0x5 → read returns 0xFFBBFFDD.
- Protocol error: awid 0x3, len 3, wlast asserted on beat 1 → bresp=2'b10, bid=0x3, and the next AW is accepted afterwards. Also awburst 2'b11 → bresp=2'b10.
- Backpressure: hold rready low for 3 cycles mid-burst while a write burst runs concurrently → R outputs stay stable, no beat is lost or duplicated, and the write completes with OKAY.
- Reset mid-read: assert reset on beat 2 of an 8-beat read → rvalid=0 the next cycle; arready=1 the cycle after release; a fresh read returns correct data.

Source files
------------

// File: rtl/axi_mem_pkg.sv
// axi_mem_pkg: shared types and helpers for the AXI4 memory responder.
// Holds the burst-type enum, response codes, per-channel FSM state enums
// and the WRAP-length legality check used by both address and response logic.
package axi_mem_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  // WRAP bursts are only defined for 2, 4, 8 or 16 beats.
  function automatic logic wrap_legal(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // Reserved burst type or a WRAP with an unsupported length earns SLVERR.
  function automatic logic burst_err(input logic [1:0] burst, input logic [7:0] len);
    return (burst == BURST_RSVD) || ((burst == BURST_WRAP) && !wrap_legal(len));
  endfunction

endpackage

// File: rtl/axi_mem_if.sv
// axi_mem_if: AXI4 burst bus bundle (AW, W, B, AR, R channels).
// Modports: master drives requests/write data/ready for responses,
// slave drives address/data readies and the B/R response channels.
interface axi_mem_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [1:0]              arburst;
  logic                    arvalid;
  logic                    arready;

  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arburst, arvalid, input arready,
    input rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input awid, awaddr, awlen, awburst, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arlen, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/axi_mem_burst_addr.sv
// axi_mem_burst_addr: combinational next-beat address generator.
// Ports: addr (current beat byte address), burst (type), len (beats-1),
// step (bytes per beat, power of two), next_addr_c (address of following beat).
// Reserved bursts and illegal WRAP lengths advance as INCR.
module axi_mem_burst_addr
  import axi_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [1:0]            burst,
  input  logic [7:0]            len,
  input  logic [ADDR_WIDTH-1:0] step,
  output logic [ADDR_WIDTH-1:0] next_addr_c
);
  logic [ADDR_WIDTH-1:0] incr_c;
  logic [ADDR_WIDTH-1:0] span_c;
  logic [ADDR_WIDTH-1:0] mask_c;

  assign incr_c = addr + step;
  // Wrap window size in bytes; step is a power of two so span-1 is a low-bit mask.
  assign span_c = (ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) * step;
  assign mask_c = span_c - ADDR_WIDTH'(1);

  always_comb begin
    next_addr_c = incr_c;
    if (burst == BURST_FIXED) begin
      next_addr_c = addr;
    end else if ((burst == BURST_WRAP) && wrap_legal(len)) begin
      next_addr_c = (addr & ~mask_c) | (incr_c & mask_c);
    end
  end
endmodule

// File: rtl/axi_mem_responder.sv
// axi_mem_responder: AXI4 slave serving bursts from an internal word memory.
// Ports: aclk (clock), reset (sync, active-high), bus (axi_mem_if slave modport).
// Independent write (IDLE/DATA/RESP) and read (IDLE/DATA) FSMs; full-width beats only.
module axi_mem_responder
  import axi_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned MEM_DEPTH  = 1024
) (
  input logic      aclk,
  input logic      reset,
  axi_mem_if.slave bus
);
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(STRB_W);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // ---------------- write channel ----------------
  w_state_e              w_state, w_state_next;
  logic [ID_WIDTH-1:0]   aw_id;
  logic [ADDR_WIDTH-1:0] aw_addr, aw_addr_next_c;
  logic [7:0]            aw_len, w_cnt;
  logic [1:0]            aw_burst;
  logic                  aw_err;
  logic                  aw_hs_c, w_hs_c, b_hs_c, w_at_len_c, w_done_c;
  logic [IDX_W-1:0]      w_idx_c;

  assign aw_hs_c    = bus.awvalid && bus.awready;
  assign w_hs_c     = bus.wvalid && bus.wready;
  assign b_hs_c     = bus.bvalid && bus.bready;
  assign w_at_len_c = (w_cnt == aw_len);
  // First of wlast or the expected beat count closes the data phase.
  assign w_done_c   = bus.wlast || w_at_len_c;
  assign w_idx_c    = aw_addr[OFF_W +: IDX_W];

  axi_mem_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_waddr (
    .addr        (aw_addr),
    .burst       (aw_burst),
    .len         (aw_len),
    .step        (STEP),
    .next_addr_c (aw_addr_next_c)
  );

  // Write next-state
  always_comb begin
    w_state_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs_c) w_state_next = W_DATA;
      W_DATA:  if (w_hs_c && w_done_c) w_state_next = W_RESP;
      W_RESP:  if (b_hs_c) w_state_next = W_IDLE;
      default: w_state_next = W_IDLE;
    endcase
  end

  // Write state, request capture and registered handshake outputs
  always_ff @(posedge aclk) begin
    if (reset) begin
      w_state     <= W_IDLE;
      bus.awready <= 1'b0;
      bus.wready  <= 1'b0;
      bus.bvalid  <= 1'b0;
      bus.bid     <= '0;
      bus.bresp   <= RESP_OKAY;
      aw_id       <= '0;
      aw_addr     <= '0;
      aw_len      <= '0;
      aw_burst    <= '0;
      aw_err      <= 1'b0;
      w_cnt       <= '0;
    end else begin
      w_state     <= w_state_next;
      bus.awready <= (w_state_next == W_IDLE);
      bus.wready  <= (w_state_next == W_DATA);
      bus.bvalid  <= (w_state_next == W_RESP);
      if (aw_hs_c) begin
        aw_id    <= bus.awid;
        aw_addr  <= bus.awaddr;
        aw_len   <= bus.awlen;
        aw_burst <= bus.awburst;
        aw_err   <= burst_err(bus.awburst, bus.awlen);
        w_cnt    <= '0;
      end
      if (w_hs_c) begin
        aw_addr <= aw_addr_next_c;
        w_cnt   <= w_cnt + 8'd1;
        if (w_done_c) begin
          bus.bid   <= aw_id;
          bus.bresp <= (aw_err || (bus.wlast != w_at_len_c)) ? RESP_SLVERR : RESP_OKAY;
        end
      end
    end
  end

  // Byte-strobed memory write; memory itself is never reset
  always_ff @(posedge aclk) begin
    if (!reset && w_hs_c) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (bus.wstrb[b]) mem[w_idx_c][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_e              r_state, r_state_next;
  logic [ADDR_WIDTH-1:0] r_addr, r_base_c, r_addr_next_c;
  logic [7:0]            r_len, r_cnt, r_len_sel_c;
  logic [1:0]            r_burst, r_burst_sel_c;
  logic                  ar_hs_c, r_hs_c;
  logic [IDX_W-1:0]      r_idx_c;

  assign ar_hs_c = bus.arvalid && bus.arready;
  assign r_hs_c  = bus.rvalid && bus.rready;
  // r_addr holds the next beat to fetch; on AR the request itself is the fetch address.
  assign r_base_c      = ar_hs_c ? bus.araddr  : r_addr;
  assign r_burst_sel_c = ar_hs_c ? bus.arburst : r_burst;
  assign r_len_sel_c   = ar_hs_c ? bus.arlen   : r_len;
  assign r_idx_c       = r_base_c[OFF_W +: IDX_W];

  axi_mem_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_raddr (
    .addr        (r_base_c),
    .burst       (r_burst_sel_c),
    .len         (r_len_sel_c),
    .step        (STEP),
    .next_addr_c (r_addr_next_c)
  );

  // Read next-state
  always_comb begin
    r_state_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs_c) r_state_next = R_DATA;
      R_DATA:  if (r_hs_c && bus.rlast) r_state_next = R_IDLE;
      default: r_state_next = R_IDLE;
    endcase
  end

  // Read state and data pipeline; rdata only advances on accepted non-last beats
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_state     <= R_IDLE;
      bus.arready <= 1'b0;
      bus.rvalid  <= 1'b0;
      bus.rlast   <= 1'b0;
      bus.rid     <= '0;
      bus.rresp   <= RESP_OKAY;
      bus.rdata   <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_burst     <= '0;
      r_cnt       <= '0;
    end else begin
      r_state     <= r_state_next;
      bus.arready <= (r_state_next == R_IDLE);
      bus.rvalid  <= (r_state_next == R_DATA);
      if (ar_hs_c) begin
        bus.rid   <= bus.arid;
        bus.rresp <= burst_err(bus.arburst, bus.arlen) ? RESP_SLVERR : RESP_OKAY;
        bus.rlast <= (bus.arlen == 8'd0);
        bus.rdata <= mem[r_idx_c];
        r_addr    <= r_addr_next_c;
        r_len     <= bus.arlen;
        r_burst   <= bus.arburst;
        r_cnt     <= '0;
      end else if (r_hs_c && !bus.rlast) begin
        bus.rdata <= mem[r_idx_c];
        bus.rlast <= ((r_cnt + 8'd1) == r_len);
        r_addr    <= r_addr_next_c;
        r_cnt     <= r_cnt + 8'd1;
      end else if (r_hs_c) begin
        bus.rlast <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axi_mem_responder.sv
// tb_axi_mem_responder: directed + randomized bench for axi_mem_responder.
// Keeps a word-array reference memory and derives beat addresses from the
// burst rules arithmetically (start, size, wrap window).
module tb_axi_mem_responder;
  localparam int unsigned AW    = 12;
  localparam int unsigned DW    = 32;
  localparam int unsigned IW    = 4;
  localparam int unsigned DEPTH = 1024;

  logic aclk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] rbuf [16];
  logic [31:0] wd  [16];
  logic [3:0]  ws  [16];
  logic [31:0] wd2 [16];
  logic [3:0]  ws2 [16];

  axi_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  axi_mem_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_DEPTH(DEPTH)
  ) dut (
    .aclk  (aclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic legal_wrap_len(input int unsigned len);
    return (len == 1) || (len == 3) || (len == 7) || (len == 15);
  endfunction

  // Byte address of beat i of a burst (12-bit address space).
  function automatic int unsigned beat_addr(input int unsigned start, input int unsigned len,
                                            input logic [1:0] burst, input int unsigned i);
    int unsigned size, base;
    if (burst == 2'b00) return start;
    if (burst == 2'b10 && legal_wrap_len(len)) begin
      size = (len + 1) * 4;
      base = (start / size) * size;
      return base + ((start - base) + i * 4) % size;
    end
    return (start + i * 4) % 4096;
  endfunction

  function automatic logic [1:0] exp_resp(input logic [1:0] burst, input int unsigned len);
    if (burst == 2'b11) return 2'b10;
    if (burst == 2'b10 && !legal_wrap_len(len)) return 2'b10;
    return 2'b00;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge. last_beat is the beat index carrying wlast.
  task automatic axi_write(input logic [3:0] id, input logic [11:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input int last_beat,
                           input logic [31:0] d [16], input logic [3:0] s [16], input string tag);
    int cyc;
    int nb;
    logic [9:0] idx;
    logic [1:0] er;
    er = (exp_resp(burst, int'(len)) != 2'b00 || last_beat != int'(len)) ? 2'b10 : 2'b00;
    bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awburst = burst; bus.awvalid = 1'b1;
    cyc = 0;
    while (bus.awready !== 1'b1 && cyc < 100) begin @(negedge aclk); cyc++; end
    chk({tag, ":awready"}, 64'(bus.awready), 64'd1);
    @(negedge aclk);
    bus.awvalid = 1'b0;
    chk({tag, ":wready_lat"}, 64'(bus.wready), 64'd1);
    nb = ((last_beat < int'(len)) ? last_beat : int'(len)) + 1;
    for (int i = 0; i < nb; i++) begin
      bus.wdata = d[i]; bus.wstrb = s[i]; bus.wlast = (i == last_beat); bus.wvalid = 1'b1;
      cyc = 0;
      while (bus.wready !== 1'b1 && cyc < 100) begin @(negedge aclk); cyc++; end
      idx = 10'(beat_addr(32'(addr), int'(len), burst, i) >> 2);
      for (int b = 0; b < 4; b++) begin
        if (s[i][b]) model_mem[idx][8*b +: 8] = d[i][8*b +: 8];
      end
      @(negedge aclk);
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    chk({tag, ":bvalid_lat"}, 64'(bus.bvalid), 64'd1);
    chk({tag, ":bid"}, 64'(bus.bid), 64'(id));
    chk({tag, ":bresp"}, 64'(bus.bresp), 64'(er));
    bus.bready = 1'b1;
    @(negedge aclk);
    bus.bready = 1'b0;
    chk({tag, ":awready_after_b"}, 64'(bus.awready), 64'd1);
  endtask

  // Called at a negedge. stall_at: beat index before which rready drops for 3 cycles (-1: none).
  task automatic axi_read(input logic [3:0] id, input logic [11:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int stall_at, input string tag);
    int cyc;
    logic [9:0] idx;
    logic [31:0] e;
    logic [1:0] er;
    er = exp_resp(burst, int'(len));
    bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arburst = burst; bus.arvalid = 1'b1;
    cyc = 0;
    while (bus.arready !== 1'b1 && cyc < 100) begin @(negedge aclk); cyc++; end
    chk({tag, ":arready"}, 64'(bus.arready), 64'd1);
    @(negedge aclk);
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      idx = 10'(beat_addr(32'(addr), int'(len), burst, i) >> 2);
      e = model_mem[idx];
      if (i == stall_at) begin
        bus.rready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          chk({tag, ":stall_rvalid"}, 64'(bus.rvalid), 64'd1);
          chk({tag, ":stall_rdata"}, 64'(bus.rdata), 64'(e));
          chk({tag, ":stall_rlast"}, 64'(bus.rlast), 64'(i == int'(len)));
          chk({tag, ":stall_rid"}, 64'(bus.rid), 64'(id));
          @(negedge aclk);
        end
        bus.rready = 1'b1;
      end
      chk({tag, ":rvalid"}, 64'(bus.rvalid), 64'd1);
      chk({tag, ":rdata"}, 64'(bus.rdata), 64'(e));
      chk({tag, ":rlast"}, 64'(bus.rlast), 64'(i == int'(len)));
      chk({tag, ":rid"}, 64'(bus.rid), 64'(id));
      chk({tag, ":rresp"}, 64'(bus.rresp), 64'(er));
      rbuf[4'(i)] = bus.rdata;
      @(negedge aclk);
    end
    bus.rready = 1'b0;
    chk({tag, ":rvalid_end"}, 64'(bus.rvalid), 64'd0);
    chk({tag, ":arready_end"}, 64'(bus.arready), 64'd1);
  endtask

  initial begin
    int cyc;
    logic [1:0] rb;
    logic [7:0] rl;
    logic [11:0] ra;
    logic [9:0] idx;

    reset = 1'b1;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    for (int i = 0; i < 16; i++) begin wd[i] = '0; ws[i] = '0; wd2[i] = '0; ws2[i] = '0; end
    repeat (3) @(negedge aclk);

    // Reset values
    chk("rst_awready", 64'(bus.awready), 64'd0);
    chk("rst_wready",  64'(bus.wready),  64'd0);
    chk("rst_bvalid",  64'(bus.bvalid),  64'd0);
    chk("rst_arready", 64'(bus.arready), 64'd0);
    chk("rst_rvalid",  64'(bus.rvalid),  64'd0);
    chk("rst_rlast",   64'(bus.rlast),   64'd0);
    chk("rst_bid",     64'(bus.bid),     64'd0);
    chk("rst_bresp",   64'(bus.bresp),   64'd0);
    chk("rst_rid",     64'(bus.rid),     64'd0);
    chk("rst_rresp",   64'(bus.rresp),   64'd0);
    chk("rst_rdata",   64'(bus.rdata),   64'd0);
    reset = 1'b0;
    @(negedge aclk);
    chk("post_rst_awready", 64'(bus.awready), 64'd1);
    chk("post_rst_arready", 64'(bus.arready), 64'd1);
    chk("post_rst_wready",  64'(bus.wready),  64'd0);

    // Fill the whole memory so every later read has a defined reference value
    for (int k = 0; k < 64; k++) begin
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
      axi_write(4'(k), 12'(k * 64), 8'd15, 2'b01, 15, wd, ws, "fill");
    end

    // INCR write then read back
    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
    for (int i = 0; i < 4; i++) ws[i] = 4'hF;
    axi_write(4'h1, 12'h100, 8'd3, 2'b01, 3, wd, ws, "incr_wr");
    axi_read(4'h2, 12'h100, 8'd3, 2'b01, -1, "incr_rd");
    chk("incr_b0", 64'(rbuf[0]), 64'h11);
    chk("incr_b3", 64'(rbuf[3]), 64'h44);

    // WRAP read starting mid-window
    for (int i = 0; i < 4; i++) wd[i] = 32'hA0 + 32'(i);
    axi_write(4'h1, 12'h100, 8'd3, 2'b01, 3, wd, ws, "wrap_fill");
    axi_read(4'h4, 12'h108, 8'd3, 2'b10, -1, "wrap_rd");
    chk("wrap_b0", 64'(rbuf[0]), 64'hA2);
    chk("wrap_b1", 64'(rbuf[1]), 64'hA3);
    chk("wrap_b2", 64'(rbuf[2]), 64'hA0);
    chk("wrap_b3", 64'(rbuf[3]), 64'hA1);

    // Byte strobes
    wd[0] = 32'hFFFF_FFFF; ws[0] = 4'hF;
    axi_write(4'h7, 12'h020, 8'd0, 2'b01, 0, wd, ws, "strb_wr1");
    wd[0] = 32'hAABB_CCDD; ws[0] = 4'h5;
    axi_write(4'h7, 12'h020, 8'd0, 2'b01, 0, wd, ws, "strb_wr2");
    axi_read(4'h7, 12'h020, 8'd0, 2'b01, -1, "strb_rd");
    chk("strb_word", 64'(rbuf[0]), 64'hFFBB_FFDD);

    // Early wlast, then a normal write must still be accepted
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hE000 + 32'(i); ws[i] = 4'hF; end
    axi_write(4'h3, 12'h040, 8'd3, 2'b01, 1, wd, ws, "early_last");
    axi_write(4'h8, 12'h040, 8'd3, 2'b01, 3, wd, ws, "after_err");
    // Reserved burst type behaves as INCR with SLVERR
    axi_write(4'h9, 12'h080, 8'd3, 2'b11, 3, wd, ws, "rsvd_wr");
    axi_read(4'h9, 12'h080, 8'd3, 2'b11, -1, "rsvd_rd");
    // Illegal WRAP length
    axi_read(4'hB, 12'h0C0, 8'd2, 2'b10, -1, "badwrap_rd");

    // Read backpressure with a concurrent write burst
    for (int i = 0; i < 16; i++) begin wd2[i] = $urandom; ws2[i] = 4'hF; end
    fork
      axi_write(4'h5, 12'h300, 8'd7, 2'b01, 7, wd2, ws2, "bp_wr");
      axi_read(4'h6, 12'h200, 8'd7, 2'b01, 3, "bp_rd");
    join
    axi_read(4'h6, 12'h300, 8'd7, 2'b01, -1, "bp_check");

    // Reset during beat 2 of an 8-beat read
    bus.arid = 4'hC; bus.araddr = 12'h400; bus.arlen = 8'd7; bus.arburst = 2'b01; bus.arvalid = 1'b1;
    cyc = 0;
    while (bus.arready !== 1'b1 && cyc < 100) begin @(negedge aclk); cyc++; end
    chk("rstrd_arready", 64'(bus.arready), 64'd1);
    @(negedge aclk);
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      idx = 10'((32'h400 + 32'(i) * 4) >> 2);
      chk("rstrd_rdata", 64'(bus.rdata), 64'(model_mem[idx]));
      @(negedge aclk);
    end
    reset = 1'b1;
    @(negedge aclk);
    chk("rstrd_rvalid_drop", 64'(bus.rvalid), 64'd0);
    bus.rready = 1'b0;
    @(negedge aclk);
    reset = 1'b0;
    @(negedge aclk);
    chk("rstrd_arready_rel", 64'(bus.arready), 64'd1);
    chk("rstrd_awready_rel", 64'(bus.awready), 64'd1);
    axi_read(4'hD, 12'h400, 8'd7, 2'b01, -1, "rstrd_fresh");

    // Randomized write/read-back bursts
    for (int n = 0; n < 24; n++) begin
      rb = 2'($urandom_range(0, 3));
      if (rb == 2'b10) begin
        case ($urandom_range(0, 4))
          0: rl = 8'd1;
          1: rl = 8'd3;
          2: rl = 8'd7;
          3: rl = 8'd15;
          default: rl = 8'd5;
        endcase
      end else begin
        rl = 8'($urandom_range(0, 15));
      end
      ra = 12'($urandom_range(0, 1023) * 4);
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15)); end
      axi_write(4'($urandom_range(0, 15)), ra, rl, rb, int'(rl), wd, ws, "rnd_wr");
      axi_read(4'($urandom_range(0, 15)), ra, rl, rb, (n % 3 == 0) ? int'(rl) / 2 : -1, "rnd_rd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
